// File: rtl/mem_ctrl_pkg.sv
// Shared types and widths for the byte-serialising memory controller.
package mem_ctrl_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int REG_W      = 32;
  localparam int BYTE_W     = 8;
  localparam int LANES      = REG_W / BYTE_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    D_READ  = 2'd1,
    D_WRITE = 2'd2,
    I_READ  = 2'd3
  } state_e;

  function automatic logic [MEM_ADDR_W-1:0] word_base(input logic [MEM_ADDR_W-1:0] addr);
    return {addr[MEM_ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Serialises 32-bit data/instruction port accesses onto a byte-wide synchronous RAM.
// Data port has fixed priority; all outputs are registered.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  d_re,
  input  logic                  d_we,
  input  logic [MEM_ADDR_W-1:0] d_addr,
  input  logic [LANES-1:0]      d_sel,
  input  logic [REG_W-1:0]      d_wdata,
  output logic [REG_W-1:0]      d_rdata,
  output logic                  d_busy,
  output logic                  d_done,
  input  logic                  i_re,
  input  logic [MEM_ADDR_W-1:0] i_addr,
  output logic [REG_W-1:0]      i_rdata,
  output logic                  i_busy,
  output logic                  i_done,
  output logic                  ram_en,
  output logic                  ram_wr,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [BYTE_W-1:0]     ram_wdata,
  input  logic [BYTE_W-1:0]     ram_rdata
);

  localparam logic [2:0] LAST_RD = 3'd4;
  localparam logic [2:0] LAST_WR = 3'd3;

  state_e state, state_nxt;
  logic [2:0] cnt, cnt_nxt;

  logic [MEM_ADDR_W-1:0] base_q, base_src, addr_full;
  logic [LANES-1:0]      sel_q, sel_src;
  logic [REG_W-1:0]      wdata_q, wdata_src;
  logic [REG_W-BYTE_W-1:0] asm_q;
  logic [1:0]            lane;
  logic                  busy_q;

  logic                  ram_en_d, ram_wr_d, busy_d, d_done_d, i_done_d;
  logic [ADDR_W-1:0]     ram_addr_d;
  logic [BYTE_W-1:0]     ram_wdata_d;
  logic                  unused_addr_hi;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (d_re)                      state_nxt = D_READ;
        else if (d_we && d_sel != '0)  state_nxt = D_WRITE;
        else if (i_re)                 state_nxt = I_READ;
      end
      D_READ, I_READ: begin
        if (cnt == LAST_RD) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 3'd1;
        end
      end
      D_WRITE: begin
        if (cnt == LAST_WR) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 3'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Values for the next cycle's registered outputs; in IDLE the request is taken straight from the ports.
  always_comb begin
    lane = cnt_nxt[1:0];
    if (state == IDLE) begin
      base_src  = word_base((state_nxt == I_READ) ? i_addr : d_addr);
      sel_src   = d_sel;
      wdata_src = d_wdata;
    end else begin
      base_src  = base_q;
      sel_src   = sel_q;
      wdata_src = wdata_q;
    end
    addr_full   = base_src + MEM_ADDR_W'(cnt_nxt);
    busy_d      = (state_nxt != IDLE);
    ram_en_d    = 1'b0;
    ram_wr_d    = 1'b0;
    ram_addr_d  = '0;
    ram_wdata_d = '0;
    unique case (state_nxt)
      D_READ, I_READ: begin
        if (cnt_nxt != LAST_RD) begin
          ram_en_d   = 1'b1;
          ram_addr_d = addr_full[ADDR_W-1:0];
        end
      end
      D_WRITE: begin
        ram_en_d    = sel_src[lane];
        ram_wr_d    = sel_src[lane];
        ram_addr_d  = addr_full[ADDR_W-1:0];
        ram_wdata_d = wdata_src[BYTE_W*lane +: BYTE_W];
      end
      default: ;
    endcase
    d_done_d = ((state == D_READ) && (cnt == LAST_RD)) || ((state == D_WRITE) && (cnt == LAST_WR));
    i_done_d = (state == I_READ) && (cnt == LAST_RD);
  end

  // Upper address bits beyond the RAM's byte address wrap away silently.
  assign unused_addr_hi = ^addr_full[MEM_ADDR_W-1:ADDR_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_en    <= 1'b0;
      ram_wr    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      busy_q    <= 1'b0;
      d_done    <= 1'b0;
      i_done    <= 1'b0;
      d_rdata   <= '0;
      i_rdata   <= '0;
    end else begin
      ram_en    <= ram_en_d;
      ram_wr    <= ram_wr_d;
      ram_addr  <= ram_addr_d;
      ram_wdata <= ram_wdata_d;
      busy_q    <= busy_d;
      d_done    <= d_done_d;
      i_done    <= i_done_d;
      if ((state == D_READ) && (cnt == LAST_RD)) d_rdata <= {ram_rdata, asm_q};
      if ((state == I_READ) && (cnt == LAST_RD)) i_rdata <= {ram_rdata, asm_q};
    end
  end

  // Request latch and little-endian assembly: bytes shift in from the top, lane 0 ends lowest.
  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      base_q  <= base_src;
      sel_q   <= sel_src;
      wdata_q <= wdata_src;
    end
    if (((state == D_READ) || (state == I_READ)) && (cnt != 3'd0) && (cnt != LAST_RD))
      asm_q <= {ram_rdata, asm_q[REG_W-BYTE_W-1:BYTE_W]};
  end

  assign d_busy = busy_q;
  assign i_busy = busy_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Randomised bench for mem_ctrl: transaction-level schedule model plus directed literal checks.
`timescale 1ns/1ps
module tb_mem_ctrl;

  localparam int          ADDR_W = 17;
  localparam int          MEM_N  = 1 << ADDR_W;
  localparam logic [31:0] MASK   = 32'h0001FFFF;

  logic              clk, rst;
  logic              d_re, d_we, i_re;
  logic [31:0]       d_addr, d_wdata, i_addr;
  logic [3:0]        d_sel;
  logic [31:0]       d_rdata, i_rdata;
  logic              d_busy, d_done, i_busy, i_done;
  logic              ram_en, ram_wr;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_wdata, ram_rdata;

  mem_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .d_re(d_re), .d_we(d_we), .d_addr(d_addr), .d_sel(d_sel), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_busy(d_busy), .d_done(d_done),
    .i_re(i_re), .i_addr(i_addr), .i_rdata(i_rdata), .i_busy(i_busy), .i_done(i_done),
    .ram_en(ram_en), .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always begin
    clk = 1'b0; #5;
    clk = 1'b1; #5;
  end

  function automatic logic [7:0] init_byte(input int a);
    if (a >= 'h100 && a <= 'h103) return 8'((a - 'h100 + 1) * 'h11);
    return 8'((a * 37 + 5) ^ (a >>> 7));
  endfunction

  // Synchronous byte RAM: read data appears the cycle after the enable cycle.
  bit [7:0] ram_mem [MEM_N];
  bit       ram_wrt [MEM_N];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_wr) begin
        ram_mem[ram_addr] <= ram_wdata;
        ram_wrt[ram_addr] <= 1'b1;
      end else begin
        ram_rdata <= ram_wrt[ram_addr] ? ram_mem[ram_addr] : init_byte(int'(ram_addr));
      end
    end
  end

  typedef struct {
    bit          en;
    bit          wr;
    logic [31:0] addr;
    logic [7:0]  wd;
    bit          busy;
    bit          dd;
    bit          id;
    logic [31:0] drd;
    logic [31:0] ird;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m_d, m_i;
  bit [7:0]    ref_mem [MEM_N];
  bit          ref_wrt [MEM_N];
  int          total, bad;
  int          n_busy, n_en, n_wr, n_dd, n_id;
  logic [31:0] first_addr, last_addr, wr_addr, wr_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_byte(input int idx);
    return ref_wrt[idx] ? ref_mem[idx] : init_byte(idx);
  endfunction

  task automatic push_read(input bit own_d, input logic [31:0] a);
    logic [31:0] b, w;
    int          idx;
    b = {a[31:2], 2'b00};
    w = '0;
    for (int k = 0; k < 4; k++) begin
      idx = int'((b + 32'(k)) & MASK);
      w[8*k +: 8] = ref_byte(idx);
      q.push_back('{en:1, wr:0, addr:32'(idx), wd:0, busy:1, dd:0, id:0, drd:m_d, ird:m_i});
    end
    q.push_back('{en:0, wr:0, addr:0, wd:0, busy:1, dd:0, id:0, drd:m_d, ird:m_i});
    if (own_d) m_d = w; else m_i = w;
    q.push_back('{en:0, wr:0, addr:0, wd:0, busy:0, dd:own_d, id:!own_d, drd:m_d, ird:m_i});
  endtask

  task automatic push_write(input logic [31:0] a, input logic [3:0] sel, input logic [31:0] wd);
    logic [31:0] b;
    int          idx;
    b = {a[31:2], 2'b00};
    for (int k = 0; k < 4; k++) begin
      idx = int'((b + 32'(k)) & MASK);
      if (sel[k]) begin
        ref_mem[idx] = wd[8*k +: 8];
        ref_wrt[idx] = 1'b1;
      end
      q.push_back('{en:sel[k], wr:sel[k], addr:32'(idx), wd:wd[8*k +: 8], busy:1, dd:0, id:0,
                    drd:m_d, ird:m_i});
    end
    q.push_back('{en:0, wr:0, addr:0, wd:0, busy:0, dd:1, id:0, drd:m_d, ird:m_i});
  endtask

  // Called at each falling edge: check this cycle, then decide what the coming edge accepts.
  task automatic step_model();
    exp_t e;
    if (rst) begin
      q.delete();
      m_d = '0;
      m_i = '0;
      chk("rst_ram_en", 32'(ram_en), 0);
      chk("rst_ram_wr", 32'(ram_wr), 0);
      chk("rst_ram_addr", 32'(ram_addr), 0);
      chk("rst_busy", 32'({d_busy, i_busy}), 0);
      chk("rst_done", 32'({d_done, i_done}), 0);
      chk("rst_d_rdata", d_rdata, 0);
      chk("rst_i_rdata", i_rdata, 0);
      return;
    end
    if (q.size() > 0) e = q.pop_front();
    else e = '{en:0, wr:0, addr:0, wd:0, busy:0, dd:0, id:0, drd:m_d, ird:m_i};
    chk("ram_en", 32'(ram_en), 32'(e.en));
    chk("ram_wr", 32'(ram_wr), 32'(e.wr));
    if (e.en) chk("ram_addr", 32'(ram_addr), e.addr);
    if (e.wr) chk("ram_wdata", 32'(ram_wdata), 32'(e.wd));
    chk("d_busy", 32'(d_busy), 32'(e.busy));
    chk("i_busy", 32'(i_busy), 32'(e.busy));
    chk("d_done", 32'(d_done), 32'(e.dd));
    chk("i_done", 32'(i_done), 32'(e.id));
    chk("d_rdata", d_rdata, e.drd);
    chk("i_rdata", i_rdata, e.ird);
    if (ram_en) begin
      if (n_en == 0) first_addr = 32'(ram_addr);
      last_addr = 32'(ram_addr);
      n_en++;
      if (ram_wr) begin
        n_wr++;
        wr_addr = 32'(ram_addr);
        wr_data = 32'(ram_wdata);
      end
    end
    if (d_busy) n_busy++;
    if (d_done) n_dd++;
    if (i_done) n_id++;
    if (q.size() == 0) begin
      if (d_re)                     push_read(1'b1, d_addr);
      else if (d_we && d_sel != 0)  push_write(d_addr, d_sel, d_wdata);
      else if (i_re)                push_read(1'b0, i_addr);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    step_model();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_stats();
    n_busy = 0; n_en = 0; n_wr = 0; n_dd = 0; n_id = 0;
    first_addr = '0; last_addr = '0; wr_addr = '0; wr_data = '0;
  endtask

  // Present a request set and hold each one until its done pulse (bounded).
  task automatic run_op(input bit dre, input bit dwe, input logic [31:0] da, input logic [3:0] sel,
                        input logic [31:0] wd, input bit ire, input logic [31:0] ia,
                        output int d_lat, output int i_lat);
    bit dp, ip;
    int t;
    d_re = dre; d_we = dwe; d_addr = da; d_sel = sel; d_wdata = wd;
    i_re = ire; i_addr = ia;
    dp = dre || (dwe && sel != 4'b0000);
    ip = ire;
    d_lat = 0; i_lat = 0; t = 0;
    do begin
      tick();
      t++;
      if (!dp) begin d_re = 1'b0; d_we = 1'b0; end
      if (dp && d_done) begin dp = 1'b0; d_lat = t; d_re = 1'b0; d_we = 1'b0; end
      if (ip && i_done) begin ip = 1'b0; i_lat = t; i_re = 1'b0; end
    end while ((dp || ip) && t < 40);
    chk("op_timeout", 32'(dp || ip), 0);
    d_re = 1'b0; d_we = 1'b0; i_re = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] hi, lo;
    hi = $urandom() & ~MASK;
    case ($urandom_range(0, 3))
      0:       lo = 32'h100 + 32'($urandom_range(0, 31));
      1:       lo = 32'h1FFF0 + 32'($urandom_range(0, 15));
      2:       lo = 32'($urandom_range(0, 63));
      default: lo = $urandom() & MASK;
    endcase
    return hi | lo;
  endfunction

  initial begin
    int dl, il, kind;
    logic [31:0] a1, a2, wd;
    logic [3:0]  sel;
    total = 0; bad = 0;
    m_d = '0; m_i = '0;
    rst = 1'b1;
    d_re = 1'b0; d_we = 1'b0; d_addr = '0; d_sel = '0; d_wdata = '0;
    i_re = 1'b0; i_addr = '0;
    clr_stats();
    tick();
    chk("reset_d_rdata", d_rdata, 0);
    chk("reset_i_rdata", i_rdata, 0);
    chk("reset_ram_en", 32'(ram_en), 0);
    chk("reset_d_busy", 32'(d_busy), 0);
    rst = 1'b0;
    tick(); tick();

    // Word read from 0x100
    clr_stats();
    run_op(1, 0, 32'h100, 4'h0, 32'h0, 0, 32'h0, dl, il);
    chk("read_latency", 32'(dl), 6);
    chk("read_word", d_rdata, 32'h44332211);
    chk("read_busy_cycles", 32'(n_busy), 5);
    chk("read_en_cycles", 32'(n_en), 4);
    chk("read_first_addr", first_addr, 32'h100);
    chk("read_last_addr", last_addr, 32'h103);
    tick();

    // Single-byte store into lane 2
    clr_stats();
    run_op(0, 1, 32'h202, 4'b0100, 32'hABABABAB, 0, 32'h0, dl, il);
    chk("store_latency", 32'(dl), 5);
    chk("store_busy_cycles", 32'(n_busy), 4);
    chk("store_writes", 32'(n_wr), 1);
    chk("store_en_cycles", 32'(n_en), 1);
    chk("store_addr", wr_addr, 32'h202);
    chk("store_data", wr_data, 32'hAB);
    chk("store_keeps_rdata", d_rdata, 32'h44332211);
    tick();

    // Data and fetch in the same cycle
    clr_stats();
    run_op(1, 0, 32'h10, 4'h0, 32'h0, 1, 32'h0, dl, il);
    chk("cont_d_latency", 32'(dl), 6);
    chk("cont_i_latency", 32'(il), 12);
    chk("cont_d_word", d_rdata, 32'hC49F7A55);
    chk("cont_i_word", i_rdata, 32'h744F2A05);
    chk("cont_d_done_count", 32'(n_dd), 1);
    chk("cont_busy_cycles", 32'(n_busy), 10);
    tick();

    // Store with no lanes enabled is dropped
    clr_stats();
    run_op(0, 1, 32'h300, 4'b0000, 32'h12345678, 0, 32'h0, dl, il);
    tick(); tick();
    chk("drop_busy", 32'(n_busy), 0);
    chk("drop_en", 32'(n_en), 0);
    chk("drop_done", 32'(n_dd), 0);
    run_op(0, 1, 32'h300, 4'b0000, 32'h12345678, 1, 32'h0, dl, il);
    chk("drop_then_fetch_latency", 32'(il), 6);
    chk("drop_then_fetch_word", i_rdata, 32'h744F2A05);
    tick();

    // Reset pulse in the third cycle of a read
    clr_stats();
    d_re = 1'b1; d_addr = 32'h100;
    tick();
    d_re = 1'b0;
    tick(); tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_ram_en", 32'(ram_en), 0);
    chk("mid_rst_busy", 32'(d_busy), 0);
    chk("mid_rst_d_rdata", d_rdata, 0);
    chk("mid_rst_i_rdata", i_rdata, 0);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("mid_rst_no_done", 32'(n_dd), 0);
    run_op(1, 0, 32'h100, 4'h0, 32'h0, 0, 32'h0, dl, il);
    chk("post_rst_latency", 32'(dl), 6);
    chk("post_rst_word", d_rdata, 32'h44332211);
    tick();

    // Address wrap at the top of the RAM
    clr_stats();
    run_op(1, 0, 32'h0001FFFC, 4'h0, 32'h0, 0, 32'h0, dl, il);
    chk("wrap_first_addr", first_addr, 32'h1FFFC);
    chk("wrap_last_addr", last_addr, 32'h1FFFF);
    clr_stats();
    run_op(1, 0, 32'h00020000, 4'h0, 32'h0, 0, 32'h0, dl, il);
    chk("wrap_zero_first", first_addr, 32'h0);
    chk("wrap_zero_last", last_addr, 32'h3);
    tick();

    // Randomised traffic against the schedule model
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 9);
      a1   = rand_addr();
      a2   = rand_addr();
      sel  = 4'($urandom_range(0, 15));
      wd   = $urandom();
      case (kind)
        0, 1, 2: run_op(1, 0, a1, sel, wd, 0, a2, dl, il);
        3, 4, 5: run_op(0, 1, a1, sel, wd, 0, a2, dl, il);
        6, 7:    run_op(0, 0, a1, sel, wd, 1, a2, dl, il);
        8:       run_op(1'($urandom_range(0, 1)), 1, a1, sel, wd, 1, a2, dl, il);
        default: run_op(1, 1, a1, sel, wd, 0, a2, dl, il);
      endcase
      repeat ($urandom_range(0, 2)) tick();
    end
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
